// File: rtl/fpga_status_led_pkg.sv
// Shared types for the board-status LED controller: channel modes, exit-code FSM states.
package fpga_status_led_pkg;

  localparam int unsigned EXIT_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOLID = 3'd1,
    ON    = 3'd2,
    OFF   = 3'd3,
    GAP   = 3'd4
  } exit_state_e;

endpackage

// File: rtl/status_led_channel.sv
// One LED channel: mode decode, blink phase, PWM compare, and an external override.
module status_led_channel
  import fpga_status_led_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  led_mode_e            mode,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 tick,
  input  logic                 ovr_en,
  input  logic                 ovr_val,
  output logic                 led
);

  logic phase;

  // Phase is held at 0 outside blink so entering blink always starts dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      led   <= 1'b0;
    end else begin
      if (mode != LED_BLINK) begin
        phase <= 1'b0;
      end else if (tick) begin
        phase <= ~phase;
      end

      if (ovr_en) begin
        led <= ovr_val;
      end else begin
        case (mode)
          LED_OFF:   led <= 1'b0;
          LED_ON:    led <= 1'b1;
          LED_BLINK: led <= phase;
          LED_PWM:   led <= (pwm_cnt < duty);
          default:   led <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Multi-channel status LED controller with exit-code blink display on EXIT_LED.
// Define FPGA_STATUS_LED_SYNC_EN to pass exit_valid_i through a 2-flop synchronizer.
module fpga_status_led_ctrl
  import fpga_status_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 4,
  parameter int unsigned CNT_WIDTH = 27,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned EXIT_LED  = 0,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CNT_WIDTH-1:0]          div_i,
  input  logic [2*NUM_LEDS-1:0]         mode_i,
  input  logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i,
  input  logic                          exit_valid_i,
  input  logic [31:0]                   exit_value_i,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic                          tick_o,
  output logic                          exit_busy_o
);

  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  logic                     ev;
  logic                     ev_prev;
  logic                     exit_start;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [CNT_WIDTH-1:0]     cnt_cur;
  logic [PWM_WIDTH-1:0]     pwm_cnt;
  exit_state_e              state;
  logic [EXIT_NIBBLE_W-1:0] exit_n;
  logic [EXIT_NIBBLE_W-1:0] remaining;
  logic [GAP_W-1:0]         gap_cnt;
  logic [EXIT_NIBBLE_W-1:0] nib;
  logic                     ovr_en;
  logic                     ovr_val;
  logic                     unused_exit_bits;

  assign nib              = exit_value_i[EXIT_NIBBLE_W-1:0];
  assign unused_exit_bits = ^exit_value_i[31:EXIT_NIBBLE_W];

`ifdef FPGA_STATUS_LED_SYNC_EN
  logic [1:0] ev_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) ev_sync <= 2'b00;
    else       ev_sync <= {ev_sync[0], exit_valid_i};
  end

  assign ev = ev_sync[1];
`else
  assign ev = exit_valid_i;
`endif

  // Reset value 0 makes a level held through reset look like a fresh rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) ev_prev <= 1'b0;
    else       ev_prev <= ev;
  end

  assign exit_start = ev && !ev_prev && (state == IDLE);

  // Exit entry restarts the tick period so every burst segment is exactly div_i+1 cycles.
  assign cnt_cur = exit_start ? '0 : cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (cnt_cur >= div_i) begin
      cnt    <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt    <= cnt_cur + CNT_WIDTH'(1);
      tick_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
  end

  // Exit-code display: n pulses of one tick on / one tick off, then GAP_TICKS dark.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      exit_busy_o <= 1'b0;
      exit_n      <= '0;
      remaining   <= '0;
      gap_cnt     <= '0;
    end else if (state != IDLE && !ev) begin
      state       <= IDLE;
      exit_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exit_start) begin
            exit_n      <= nib;
            remaining   <= nib;
            gap_cnt     <= '0;
            exit_busy_o <= 1'b1;
            state       <= (nib == '0) ? SOLID : ON;
          end
        end
        SOLID: state <= SOLID;
        ON: begin
          if (tick_o) state <= OFF;
        end
        OFF: begin
          if (tick_o) begin
            if (remaining > EXIT_NIBBLE_W'(1)) begin
              remaining <= remaining - EXIT_NIBBLE_W'(1);
              state     <= ON;
            end else begin
              remaining <= '0;
              gap_cnt   <= '0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (tick_o) begin
            if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
              gap_cnt   <= '0;
              remaining <= exit_n;
              state     <= ON;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state       <= IDLE;
          exit_busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Gating with the live level releases the channel on the same edge the FSM idles.
  assign ovr_en  = ev && (state != IDLE);
  assign ovr_val = (state == SOLID) || (state == ON);

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    localparam bit IS_EXIT = (i == int'(EXIT_LED));

    status_led_channel #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_ch (
      .clk     (clk_i),
      .rst     (rst_i),
      .mode    (led_mode_e'(mode_i[2*i +: 2])),
      .duty    (duty_i[PWM_WIDTH*i +: PWM_WIDTH]),
      .pwm_cnt (pwm_cnt),
      .tick    (tick_o),
      .ovr_en  (IS_EXIT ? ovr_en : 1'b0),
      .ovr_val (ovr_val),
      .led     (led_o[i])
    );
  end

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed bench for fpga_status_led_ctrl: vector table plus multi-cycle exit-code sequences.
module tb_fpga_status_led_ctrl;

`ifdef FPGA_STATUS_LED_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [26:0] div_i = 27'd3;
  logic [7:0]  mode_i = 8'h55;
  logic [31:0] duty_i = 32'h0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = 32'h0;
  logic [3:0]  led_o;
  logic        tick_o;
  logic        exit_busy_o;

  int checks = 0;
  int errors = 0;

  fpga_status_led_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .div_i        (div_i),
    .mode_i       (mode_i),
    .duty_i       (duty_i),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .led_o        (led_o),
    .tick_o       (tick_o),
    .exit_busy_o  (exit_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [26:0] div;
    logic [7:0]  mode;
    logic [3:0]  exp_led;
    logic        exp_tick;
  } vec_t;

  vec_t vecs[17];

  // Exit code 3 with div_i=1 as seen on led_o[0], one entry per cycle, period 20.
  bit pat[20] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;

    vecs[0]  = '{1'b1, 27'd3, 8'h55, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 27'd3, 8'h55, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b0};
    vecs[3]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b0};
    vecs[4]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b0};
    vecs[5]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b1};
    vecs[6]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b0};
    vecs[7]  = '{1'b0, 27'd3, 8'h55, 4'hF, 1'b0};
    vecs[8]  = '{1'b0, 27'd1, 8'h55, 4'hF, 1'b1};
    vecs[9]  = '{1'b0, 27'd1, 8'h55, 4'hF, 1'b0};
    vecs[10] = '{1'b0, 27'd1, 8'h55, 4'hF, 1'b1};
    vecs[11] = '{1'b0, 27'd1, 8'h55, 4'hF, 1'b0};
    vecs[12] = '{1'b0, 27'd1, 8'h55, 4'hF, 1'b1};
    vecs[13] = '{1'b0, 27'd1, 8'h00, 4'h0, 1'b0};
    vecs[14] = '{1'b0, 27'd1, 8'h01, 4'h1, 1'b1};
    vecs[15] = '{1'b0, 27'd1, 8'h40, 4'h8, 1'b0};
    vecs[16] = '{1'b1, 27'd1, 8'h55, 4'h0, 1'b0};

    // Reset, prescaler period, div lowered mid-count, mode latency.
    for (int i = 0; i < 17; i++) begin
      rst_i  = vecs[i].rst;
      div_i  = vecs[i].div;
      mode_i = vecs[i].mode;
      step();
      chk($sformatf("vec%0d_led", i), 32'(led_o), 32'(vecs[i].exp_led));
      chk($sformatf("vec%0d_tick", i), 32'(tick_o), 32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_busy", i), 32'(exit_busy_o), 32'd0);
    end

    // Blink on ch1 with a tick every cycle.
    rst_i  = 1'b0;
    div_i  = 27'd0;
    mode_i = 8'h00;
    step();
    step();
    mode_i = 8'h08;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("blink_%0d", k), 32'(led_o), (k % 2 == 1) ? 32'h2 : 32'h0);
    end

    // PWM on ch2: high-cycle count over one full period.
    mode_i = 8'h30;
    for (int d = 0; d < 3; d++) begin
      logic [7:0] duty;
      duty   = (d == 0) ? 8'd64 : ((d == 1) ? 8'd0 : 8'd255);
      duty_i = {8'h00, duty, 8'h00, 8'h00};
      step();
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        step();
        if (led_o[2]) hi++;
      end
      chk($sformatf("pwm_duty_%0d", duty), 32'(hi), 32'(duty));
    end

    // Exit code 3 burst pattern; value change while busy is ignored.
    mode_i       = 8'h00;
    duty_i       = 32'h0;
    div_i        = 27'd1;
    step();
    exit_value_i = 32'h13;
    exit_valid_i = 1'b1;
    for (int s = 0; s < SYNC_LAT; s++) begin
      step();
      chk("exit3_sync_wait", 32'(exit_busy_o), 32'd0);
    end
    step();
    chk("exit3_busy", 32'(exit_busy_o), 32'd1);
    chk("exit3_led_entry", 32'(led_o), 32'h0);
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) exit_value_i = 32'h5;
      step();
      chk($sformatf("exit3_led_%0d", k), 32'(led_o), 32'(pat[(k - 1) % 20]));
      chk($sformatf("exit3_busy_%0d", k), 32'(exit_busy_o), 32'd1);
    end

    // Abort from the burst.
    exit_valid_i = 1'b0;
    for (int s = 0; s < SYNC_LAT; s++) begin
      step();
      chk("abort3_busy_hold", 32'(exit_busy_o), 32'd1);
    end
    step();
    chk("abort3_busy", 32'(exit_busy_o), 32'd0);
    chk("abort3_led", 32'(led_o), 32'h0);

    // Exit code 0: solid on, then drop and follow mode_i.
    exit_value_i = 32'h0;
    exit_valid_i = 1'b1;
    for (int s = 0; s < SYNC_LAT; s++) begin
      step();
      chk("exit0_sync_wait", 32'(exit_busy_o), 32'd0);
    end
    step();
    chk("exit0_busy", 32'(exit_busy_o), 32'd1);
    chk("exit0_led_entry", 32'(led_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("exit0_solid_%0d", k), 32'(led_o), 32'h1);
    end
    exit_valid_i = 1'b0;
    for (int s = 0; s < SYNC_LAT; s++) begin
      step();
      chk("exit0_drop_hold", 32'(led_o), 32'h1);
    end
    step();
    chk("exit0_drop_busy", 32'(exit_busy_o), 32'd0);
    chk("exit0_drop_led", 32'(led_o), 32'h0);
    mode_i = 8'h01;
    step();
    chk("exit0_follow_mode", 32'(led_o), 32'h1);

    // Reset in the middle of GAP, then re-entry with exit_valid_i held through reset.
    mode_i       = 8'h00;
    exit_value_i = 32'h13;
    exit_valid_i = 1'b1;
    for (int s = 0; s < SYNC_LAT; s++) step();
    step();
    for (int k = 0; k < 15; k++) step();
    chk("gap_led", 32'(led_o), 32'h0);
    chk("gap_busy", 32'(exit_busy_o), 32'd1);
    rst_i  = 1'b1;
    mode_i = 8'h54;
    step();
    chk("gaprst_led", 32'(led_o), 32'h0);
    chk("gaprst_tick", 32'(tick_o), 32'd0);
    chk("gaprst_busy", 32'(exit_busy_o), 32'd0);
    step();
    rst_i = 1'b0;
    for (int s = 0; s < SYNC_LAT; s++) begin
      step();
      chk("reentry_sync_wait", 32'(exit_busy_o), 32'd0);
    end
    step();
    chk("reentry_busy", 32'(exit_busy_o), 32'd1);
    chk("reentry_led0", 32'(led_o), 32'hE);
    step();
    chk("reentry_led1", 32'(led_o), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
